// File: rtl/ocl_axil_reg_bridge.sv
// rtl/ocl_axil_reg_bridge.sv - AXI4-Lite slave to single-cycle register strobe bridge
// Independent read/write FSMs; a saturating wait counter turns a silent backend into SLVERR.
module ocl_axil_reg_bridge #(
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_n,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [31:0]       reg_wr_data,
  output logic [3:0]        reg_wr_strb,
  input  logic              reg_wr_ack,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [31:0]       reg_rd_data,
  input  logic              reg_rd_valid
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_COLLECT, W_ISSUE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic              live;
  logic              aw_held, w_held, aw_hs, w_hs, w_done, w_tout;
  logic              ar_hs, r_done, r_tout;
  logic [CNT_W-1:0]  w_cnt, r_cnt;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [31:0]       w_data_q, rdata_q;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q, rresp_q;

  // Readies stay low while in reset and rise on the first clock after release.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      live    <= 1'b0;
      w_state <= W_COLLECT;
      r_state <= R_IDLE;
    end else begin
      live    <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    reg_wr_en = 1'b0;
    s_bvalid  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    w_done    = 1'b0;
    w_tout    = 1'b0;
    case (w_state)
      W_COLLECT: begin
        s_awready = live && !aw_held;
        s_wready  = live && !w_held;
        aw_hs     = s_awvalid && s_awready;
        w_hs      = s_wvalid && s_wready;
        if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_ISSUE;
      end
      W_ISSUE, W_WAIT: begin
        reg_wr_en = (w_state == W_ISSUE);
        w_done    = reg_wr_ack;
        w_tout    = !reg_wr_ack && (w_cnt == CNT_MAX);
        w_next    = (w_done || w_tout) ? W_RESP : W_WAIT;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_next = W_COLLECT;
      end
      default: w_next = W_COLLECT;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    reg_rd_en = 1'b0;
    s_rvalid  = 1'b0;
    r_done    = 1'b0;
    r_tout    = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = live;
        if (s_arvalid && live) r_next = R_ISSUE;
      end
      R_ISSUE, R_WAIT: begin
        reg_rd_en = (r_state == R_ISSUE);
        r_done    = reg_rd_valid;
        r_tout    = !reg_rd_valid && (r_cnt == CNT_MAX);
        r_next    = (r_done || r_tout) ? R_RESP : R_WAIT;
      end
      R_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs = s_arvalid && s_arready;

  // Wait counters restart while idle so they read zero on the issue cycle.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_cnt     <= '0;
      bresp_q   <= '0;
      ar_addr_q <= '0;
      r_cnt     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      if (w_state == W_RESP && s_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (w_state == W_COLLECT)  w_cnt <= '0;
      else if (w_cnt != CNT_MAX) w_cnt <= w_cnt + 1'b1;
      if (w_done)      bresp_q <= RESP_OKAY;
      else if (w_tout) bresp_q <= RESP_SLVERR;

      if (ar_hs) ar_addr_q <= s_araddr;
      if (r_state == R_IDLE)     r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (r_done) begin
        rdata_q <= reg_rd_data;
        rresp_q <= RESP_OKAY;
      end else if (r_tout) begin
        rdata_q <= ERR_DATA;
        rresp_q <= RESP_SLVERR;
      end
    end
  end

  assign reg_wr_addr = aw_addr_q;
  assign reg_wr_data = w_data_q;
  assign reg_wr_strb = w_strb_q;
  assign reg_rd_addr = ar_addr_q;
  assign s_bresp     = bresp_q;
  assign s_rdata     = rdata_q;
  assign s_rresp     = rresp_q;

endmodule

// File: tb/tb_ocl_axil_reg_bridge.sv
// tb/tb_ocl_axil_reg_bridge.sv - self-checking bench for ocl_axil_reg_bridge
// The backend model acks after a chosen delay; expectations come from delay vs TIMEOUT.
module tb_ocl_axil_reg_bridge;

  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n  = 1'b0;
  logic        s_awvalid = 1'b0, s_awready;
  logic [31:0] s_awaddr  = '0;
  logic        s_wvalid  = 1'b0, s_wready;
  logic [31:0] s_wdata   = '0;
  logic [3:0]  s_wstrb   = '0;
  logic        s_bvalid, s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic        s_arvalid = 1'b0, s_arready;
  logic [31:0] s_araddr  = '0;
  logic        s_rvalid, s_rready = 1'b0;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        reg_wr_en, reg_rd_en;
  logic [31:0] reg_wr_addr, reg_wr_data, reg_rd_addr;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_ack   = 1'b0;
  logic [31:0] reg_rd_data  = '0;
  logic        reg_rd_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // backend model state
  int          wr_delay = -1, rd_delay = -1, wr_k = -1, rd_k = -1;
  int          wr_strobes = 0, rd_strobes = 0, wr_strobe_cyc = 0, rd_strobe_cyc = 0;
  logic [31:0] wr_addr_seen, wr_data_seen, rd_addr_seen, rd_value;
  logic [3:0]  wr_strb_seen;

  ocl_axil_reg_bridge #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_wr_ack(reg_wr_ack),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .reg_rd_valid(reg_rd_valid)
  );

  always #5 clk_main_a0 = ~clk_main_a0;
  always @(posedge clk_main_a0) cyc <= cyc + 1;

  always @(posedge clk_main_a0) begin
    #1;
    if (reg_wr_en === 1'b1) begin
      wr_strobes++;
      wr_strobe_cyc = cyc;
      wr_addr_seen  = reg_wr_addr;
      wr_data_seen  = reg_wr_data;
      wr_strb_seen  = reg_wr_strb;
      wr_k = 0;
    end else if (wr_k >= 0) wr_k++;
    reg_wr_ack = (wr_k >= 0) && (wr_k == wr_delay);
    if (reg_rd_en === 1'b1) begin
      rd_strobes++;
      rd_strobe_cyc = cyc;
      rd_addr_seen  = reg_rd_addr;
      rd_k = 0;
    end else if (rd_k >= 0) rd_k++;
    reg_rd_valid = (rd_k >= 0) && (rd_k == rd_delay);
    reg_rd_data  = reg_rd_valid ? rd_value : $urandom;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lag, input int w_lag, input int delay, input int bready_lag);
    int n, hs_cyc, s0, lat;
    bit aw_ok, w_ok, rdy_bad, hold_bad;
    logic [1:0] exp_resp;
    aw_ok = 0; w_ok = 0; rdy_bad = 0; hold_bad = 0; n = 0; hs_cyc = 0;
    wr_delay = delay;
    s0 = wr_strobes;
    exp_resp = (delay <= TIMEOUT) ? 2'b00 : 2'b10;
    lat = (delay <= TIMEOUT) ? delay + 1 : TIMEOUT + 1;
    while (!(aw_ok && w_ok) && n < 50) begin
      s_awaddr  = addr;
      s_wdata   = data;
      s_wstrb   = strb;
      s_awvalid = !aw_ok && (n >= aw_lag);
      s_wvalid  = !w_ok && (n >= w_lag);
      if (s_awvalid && s_awready) aw_ok = 1;
      if (s_wvalid && s_wready) w_ok = 1;
      hs_cyc = cyc;
      step();
      n++;
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("wr_handshakes", {aw_ok, w_ok}, 2'b11);
    n = 0;
    while (s_bvalid !== 1'b1 && n < 40) begin
      if (s_awready !== 1'b0 || s_wready !== 1'b0) rdy_bad = 1;
      step();
      n++;
    end
    chk("bvalid_seen", s_bvalid, 1'b1);
    chk("wr_strobe_count", wr_strobes - s0, 1);
    chk("wr_strobe_cyc", wr_strobe_cyc, hs_cyc + 1);
    chk("wr_addr", wr_addr_seen, addr);
    chk("wr_data", wr_data_seen, data);
    chk("wr_strb", wr_strb_seen, strb);
    chk("bvalid_cyc", cyc, wr_strobe_cyc + lat);
    chk("bresp", s_bresp, exp_resp);
    for (int i = 0; i < bready_lag; i++) begin
      if (s_awready !== 1'b0 || s_wready !== 1'b0) rdy_bad = 1;
      step();
      if (s_bvalid !== 1'b1 || s_bresp !== exp_resp) hold_bad = 1;
    end
    chk("wr_ready_low_busy", rdy_bad, 1'b0);
    chk("bvalid_hold", hold_bad, 1'b0);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("bvalid_clear", s_bvalid, 1'b0);
    chk("wr_ready_back", {s_awready, s_wready}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] addr, input int delay, input logic [31:0] value,
                         input int rready_lag);
    int n, hs_cyc, s0, lat;
    bit rdy_bad, hold_bad;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    rdy_bad = 0; hold_bad = 0; n = 0;
    rd_delay = delay;
    rd_value = value;
    s0 = rd_strobes;
    exp_data = (delay <= TIMEOUT) ? value : ERR_DATA;
    exp_resp = (delay <= TIMEOUT) ? 2'b00 : 2'b10;
    lat = (delay <= TIMEOUT) ? delay + 1 : TIMEOUT + 1;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    while (s_arready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ar_handshake", s_arready, 1'b1);
    hs_cyc = cyc;
    step();
    s_arvalid = 1'b0;
    n = 0;
    while (s_rvalid !== 1'b1 && n < 40) begin
      if (s_arready !== 1'b0) rdy_bad = 1;
      step();
      n++;
    end
    chk("rvalid_seen", s_rvalid, 1'b1);
    chk("rd_strobe_count", rd_strobes - s0, 1);
    chk("rd_strobe_cyc", rd_strobe_cyc, hs_cyc + 1);
    chk("rd_addr", rd_addr_seen, addr);
    chk("rvalid_cyc", cyc, rd_strobe_cyc + lat);
    chk("rdata", s_rdata, exp_data);
    chk("rresp", s_rresp, exp_resp);
    for (int i = 0; i < rready_lag; i++) begin
      if (s_arready !== 1'b0) rdy_bad = 1;
      step();
      if (s_rvalid !== 1'b1 || s_rdata !== exp_data || s_rresp !== exp_resp) hold_bad = 1;
    end
    chk("rd_ready_low_busy", rdy_bad, 1'b0);
    chk("rdata_hold", hold_bad, 1'b0);
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    chk("rvalid_clear", s_rvalid, 1'b0);
    chk("arready_back", s_arready, 1'b1);
  endtask

  initial begin
    int wd, rd;
    logic [3:0] st;
    #2;
    chk("reset_readies", {s_awready, s_wready, s_arready}, 3'b000);
    chk("reset_valids", {s_bvalid, s_rvalid, reg_wr_en, reg_rd_en}, 4'b0000);
    chk("reset_data", {s_rdata, s_bresp, s_rresp}, 36'h0);
    step();
    rst_main_n = 1'b1;
    chk("readies_before_clock", {s_awready, s_wready, s_arready}, 3'b000);
    step();
    chk("readies_after_release", {s_awready, s_wready, s_arready}, 3'b111);

    do_write(32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0);
    do_write(32'h14, 32'h0BAD_F00D, 4'hF, 3, 0, 5, 4);
    do_read(32'h24, 3, 32'h0000_0123, 3);
    do_write(32'h30, 32'h1111_2222, 4'h0, 0, 1, 1, 0);
    do_write(32'h34, 32'h3333_4444, 4'h5, 0, 0, TIMEOUT, 1);
    do_read(32'h38, TIMEOUT, 32'h5555_6666, 0);
    do_write(32'h50, 32'h7777_8888, 4'hC, 0, 0, TIMEOUT + 1, 2);
    do_read(32'h54, TIMEOUT + 1, 32'h9999_AAAA, 2);

    fork
      do_write(32'h40, 32'h1234_5678, 4'h3, 0, 0, 1, 2);
      do_read(32'h80, 4, 32'hCAFE_0042, 1);
    join
    chk("concurrent_strobe_cyc", rd_strobe_cyc, wr_strobe_cyc);

    for (int i = 0; i < 10; i++) begin
      wd = $urandom_range(TIMEOUT + 3, 0);
      rd = $urandom_range(TIMEOUT + 3, 0);
      st = ($urandom_range(3, 0) == 0) ? 4'h0 : 4'($urandom);
      if (i % 3 == 2) begin
        fork
          do_write($urandom, $urandom, st, $urandom_range(3, 0), $urandom_range(3, 0), wd,
                   $urandom_range(3, 0));
          do_read($urandom, rd, $urandom, $urandom_range(3, 0));
        join
      end else begin
        do_write($urandom, $urandom, st, $urandom_range(3, 0), $urandom_range(3, 0), wd,
                 $urandom_range(3, 0));
        do_read($urandom, rd, $urandom, $urandom_range(3, 0));
      end
    end

    // reset while both channels wait on a silent backend
    wr_delay  = -1;
    rd_delay  = -1;
    s_awaddr  = 32'h60;
    s_wdata   = 32'h6060_6060;
    s_wstrb   = 4'hF;
    s_araddr  = 32'h64;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_arvalid = 1'b1;
    chk("pre_reset_readies", {s_awready, s_wready, s_arready}, 3'b111);
    step();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_arvalid = 1'b0;
    chk("pre_reset_strobes", {reg_wr_en, reg_rd_en}, 2'b11);
    step();
    step();
    #2;
    rst_main_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, reg_wr_en, reg_rd_en},
        7'b0);
    chk("mid_reset_payload", {reg_wr_addr, reg_rd_addr}, 64'h0);
    step();
    rst_main_n = 1'b1;
    step();
    chk("post_reset_readies", {s_awready, s_wready, s_arready}, 3'b111);
    s_bready = 1'b1;
    s_rready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin
        chk("no_resp_after_reset", {s_bvalid, s_rvalid}, 2'b00);
        break;
      end
      step();
    end
    s_bready = 1'b0;
    s_rready = 1'b0;
    do_read(32'h68, 2, 32'h0F0F_1234, 1);
    do_write(32'h6C, 32'hFEED_0001, 4'h9, 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
